// File: rtl/gfx_fetch.sv
// Tile-plane fetcher: reads six plane bytes per 8-pixel cell from VRAM and
// presents them, aligned with an 8-clk delayed raster, to the pixel stage.
module gfx_fetch #(
    parameter logic [12:0] LINE_BASE = 13'h0EC0,
    parameter int          H_ACTIVE  = 192,
    parameter int          V_ACTIVE  = 184
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [8:0] h,
    input  logic [8:0] v,
    output logic [2:0] vram_bank,
    output logic [12:0] vram_addr,
    output logic       vram_rd,
    input  logic [7:0] vram_data,
    input  logic       cpu_req,
    output logic       cpu_grant,
    output logic [7:0] fg1,
    output logic [7:0] fg2,
    output logic [7:0] fg3,
    output logic [7:0] bg1,
    output logic [7:0] bg2,
    output logic [7:0] bg3,
    output logic [8:0] h_out,
    output logic [8:0] v_out
);

    localparam logic [8:0] H_LIM = 9'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

    logic [2:0]  slot;
    logic        in_range;
    logic        active_q;
    logic        cell_active;
    logic        rd_q;
    logic [13:0] v_x24;
    logic [7:0]  stage [6];
    logic [8:0]  h_dly [8];
    logic [8:0]  v_dly [8];

    assign slot     = h[2:0];
    assign in_range = (h < H_LIM) && (v < V_LIM);

    // The active decision is taken live on slot 0 and then held for the cell.
    assign cell_active = (slot == 3'd0) ? in_range : active_q;

    assign v_x24     = ({5'b0, v} << 4) + ({5'b0, v} << 3);
    assign vram_addr = 13'(LINE_BASE + v_x24[12:0] + {7'b0, h[8:3]});
    assign vram_bank = slot;
    assign vram_rd   = reset_n && cell_active && (slot < 3'd6);

    // CPU handshake: cpu_req is a per-cycle request; cpu_grant means the CPU
    // owns the VRAM port this same cycle. Fetch slots always win, so the two
    // strobes are mutually exclusive by construction.
    assign cpu_grant = cpu_req && !vram_rd;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            rd_q     <= 1'b0;
            fg1 <= 8'h00; fg2 <= 8'h00; fg3 <= 8'h00;
            bg1 <= 8'h00; bg2 <= 8'h00; bg3 <= 8'h00;
            for (int k = 0; k < 6; k++) stage[k] <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                h_dly[k] <= 9'd0;
                v_dly[k] <= 9'd0;
            end
        end else begin
            if (slot == 3'd0) active_q <= in_range;
            rd_q <= vram_rd;

            // Data for the read issued in slot k lands one clk later, in slot k+1.
            for (int k = 0; k < 6; k++) begin
                if (rd_q && slot == 3'(k + 1)) stage[k] <= vram_data;
            end

            if (slot == 3'd7) begin
                fg1 <= active_q ? stage[0] : 8'h00;
                fg2 <= active_q ? stage[1] : 8'h00;
                fg3 <= active_q ? stage[2] : 8'h00;
                bg1 <= active_q ? stage[3] : 8'h00;
                bg2 <= active_q ? stage[4] : 8'h00;
                bg3 <= active_q ? stage[5] : 8'h00;
            end

            h_dly[0] <= h;
            v_dly[0] <= v;
            for (int k = 1; k < 8; k++) begin
                h_dly[k] <= h_dly[k-1];
                v_dly[k] <= v_dly[k-1];
            end
        end
    end

    assign h_out = h_dly[7];
    assign v_out = v_dly[7];

endmodule

// File: tb/tb_gfx_fetch.sv
// Bench for gfx_fetch: directed scenarios plus a full-frame run against a
// behavioural VRAM/raster model.
module tb_gfx_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  h, v;
    logic [2:0]  vram_bank;
    logic [12:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_data = 8'h00;
    logic        cpu_req, cpu_grant;
    logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
    logic [8:0]  h_out, v_out;
    logic [47:0] outs;

    localparam int LB = 'h0EC0;

    logic [7:0] mem [0:6*8192-1];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gfx_fetch dut (
        .clk(clk), .reset_n(reset_n), .h(h), .v(v),
        .vram_bank(vram_bank), .vram_addr(vram_addr), .vram_rd(vram_rd),
        .vram_data(vram_data), .cpu_req(cpu_req), .cpu_grant(cpu_grant),
        .fg1(fg1), .fg2(fg2), .fg3(fg3), .bg1(bg1), .bg2(bg2), .bg3(bg3),
        .h_out(h_out), .v_out(v_out)
    );

    assign outs = {fg1, fg2, fg3, bg1, bg2, bg3};

    // VRAM: one-clock read latency
    always @(posedge clk) begin
        if (vram_rd === 1'b1) vram_data <= mem[int'(vram_bank) * 8192 + int'(vram_addr)];
    end

    function automatic logic [12:0] cell_addr(int vv, int hh);
        return 13'((LB + vv * 24 + hh / 8) % 8192);
    endfunction

    // Six plane bytes expected for the cell containing pixel hh of line vv.
    function automatic logic [47:0] cell_bytes(int vv, int hh);
        logic [47:0] r = 48'h0;
        if (hh < 192 && vv < 184) begin
            for (int k = 0; k < 6; k++) r = {r[39:0], mem[k * 8192 + int'(cell_addr(vv, hh))]};
        end
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            h = 9'($urandom_range(0, 511));
            v = 9'($urandom_range(0, 511));
            cpu_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (outs !== 48'h0) begin n_err++; $display("FAIL reset_outs got %h want 0", outs); end
                n_cmp++;
                if ({h_out, v_out} !== 18'h0) begin n_err++; $display("FAIL reset_hv got %0d/%0d want 0/0", h_out, v_out); end
            end
            n_cmp++;
            if (vram_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd got %b want 0", vram_rd); end
            n_cmp++;
            if (cpu_grant !== cpu_req) begin n_err++; $display("FAIL reset_grant got %b want %b", cpu_grant, cpu_req); end
            next_cycle();
        end
    endtask

    task automatic test_first_cell();
        for (int k = 0; k < 6; k++) mem[k * 8192 + LB] = 8'(8'h11 * (k + 1));
        reset_n = 1'b0; h = 9'd0; v = 9'd0; cpu_req = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        for (int hh = 0; hh <= 8; hh++) begin
            h = 9'(hh);
            @(negedge clk);
            if (hh < 6) begin
                n_cmp++;
                if ({vram_rd, vram_bank, vram_addr} !== {1'b1, 3'(hh), 13'h0EC0}) begin
                    n_err++; $display("FAIL first_read h=%0d got rd=%b bank=%0d addr=%h", hh, vram_rd, vram_bank, vram_addr);
                end
            end else if (hh < 8) begin
                n_cmp++;
                if (vram_rd !== 1'b0) begin n_err++; $display("FAIL first_idle h=%0d got rd=%b want 0", hh, vram_rd); end
            end else begin
                n_cmp++;
                if (outs !== 48'h112233445566) begin n_err++; $display("FAIL first_outs got %h want 112233445566", outs); end
                n_cmp++;
                if ({h_out, v_out} !== 18'h0) begin n_err++; $display("FAIL first_hv got %0d/%0d want 0/0", h_out, v_out); end
            end
            next_cycle();
        end
    endtask

    task automatic test_last_cell();
        v = 9'd183; cpu_req = 1'b0;
        for (int hh = 184; hh <= 192; hh++) begin
            h = 9'(hh);
            @(negedge clk);
            if (hh < 190) begin
                n_cmp++;
                if ({vram_rd, vram_bank, vram_addr} !== {1'b1, 3'(hh - 184), 13'h1FFF}) begin
                    n_err++; $display("FAIL last_read h=%0d got rd=%b bank=%0d addr=%h want addr 1fff", hh, vram_rd, vram_bank, vram_addr);
                end
            end
            if (hh == 192) begin
                n_cmp++;
                if (outs !== cell_bytes(183, 184)) begin n_err++; $display("FAIL last_outs got %h want %h", outs, cell_bytes(183, 184)); end
                n_cmp++;
                if ({h_out, v_out} !== {9'd184, 9'd183}) begin n_err++; $display("FAIL last_hv got %0d/%0d want 184/183", h_out, v_out); end
            end
            next_cycle();
        end
    endtask

    task automatic test_inactive();
        v = 9'($urandom_range(0, 183)); cpu_req = 1'b1;
        for (int hh = 192; hh <= 200; hh++) begin
            h = 9'(hh);
            @(negedge clk);
            if (hh < 200) begin
                n_cmp++;
                if ({vram_rd, cpu_grant} !== 2'b01) begin n_err++; $display("FAIL inactive h=%0d got rd=%b grant=%b want 0/1", hh, vram_rd, cpu_grant); end
            end else begin
                n_cmp++;
                if (outs !== 48'h0) begin n_err++; $display("FAIL inactive_outs got %h want 0", outs); end
            end
            next_cycle();
        end
    endtask

    task automatic test_cpu_priority();
        int n = $urandom_range(0, 22);
        int vv = $urandom_range(0, 183);
        v = 9'(vv); cpu_req = 1'b1;
        for (int hh = 8 * n; hh <= 8 * n + 8; hh++) begin
            h = 9'(hh);
            @(negedge clk);
            if (hh < 8 * n + 8) begin
                n_cmp++;
                if (cpu_grant !== ((hh % 8) >= 6)) begin n_err++; $display("FAIL prio_grant h=%0d got %b want %b", hh, cpu_grant, (hh % 8) >= 6); end
                if (hh % 8 < 6) begin
                    n_cmp++;
                    if ({vram_rd, vram_addr} !== {1'b1, cell_addr(vv, hh)}) begin
                        n_err++; $display("FAIL prio_read h=%0d got rd=%b addr=%h want 1/%h", hh, vram_rd, vram_addr, cell_addr(vv, hh));
                    end
                end
            end else begin
                n_cmp++;
                if (outs !== cell_bytes(vv, 8 * n)) begin n_err++; $display("FAIL prio_outs got %h want %h", outs, cell_bytes(vv, 8 * n)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_mid_reset();
        int n = $urandom_range(1, 21);
        int vv = $urandom_range(0, 183);
        v = 9'(vv); cpu_req = 1'b0;
        for (int hh = 8 * (n - 1); hh <= 8 * n + 16; hh++) begin
            h = 9'(hh);
            reset_n = (hh == 8 * n + 3) ? 1'b0 : 1'b1;
            cpu_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hh == 8 * n) begin
                n_cmp++;
                if (outs !== cell_bytes(vv, 8 * (n - 1))) begin n_err++; $display("FAIL mreset_pre got %h want %h", outs, cell_bytes(vv, 8 * (n - 1))); end
            end
            if (hh == 8 * n + 3) begin
                n_cmp++;
                if ({vram_rd, cpu_grant} !== {1'b0, cpu_req}) begin n_err++; $display("FAIL mreset_during got rd=%b grant=%b want 0/%b", vram_rd, cpu_grant, cpu_req); end
            end
            if (hh == 8 * n + 4) begin
                n_cmp++;
                if ({outs, vram_rd, h_out, v_out} !== 67'h0) begin
                    n_err++; $display("FAIL mreset_after got outs=%h rd=%b hv=%0d/%0d want all 0", outs, vram_rd, h_out, v_out);
                end
            end
            if (hh == 8 * n + 8) begin
                n_cmp++;
                if ({vram_rd, vram_addr} !== {1'b1, cell_addr(vv, hh)}) begin n_err++; $display("FAIL mreset_resume got rd=%b addr=%h", vram_rd, vram_addr); end
                n_cmp++;
                if (outs !== 48'h0) begin n_err++; $display("FAIL mreset_abort got %h want 0", outs); end
            end
            if (hh == 8 * n + 16) begin
                n_cmp++;
                if (outs !== cell_bytes(vv, 8 * (n + 1))) begin n_err++; $display("FAIL mreset_next got %h want %h", outs, cell_bytes(vv, 8 * (n + 1))); end
            end
            next_cycle();
        end
        reset_n = 1'b1;
    endtask

    task automatic test_h_jump();
        int seq[$];
        int vv = $urandom_range(0, 183);
        seq = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13, 14, 15};
        for (int hh = 16; hh <= 24; hh++) seq.push_back(hh);
        v = 9'(vv); cpu_req = 1'b1;
        foreach (seq[i]) begin
            h = 9'(seq[i]);
            @(negedge clk);
            n_cmp++;
            if (vram_rd !== (seq[i] % 8 < 6)) begin n_err++; $display("FAIL jump_rd step=%0d h=%0d got %b want %b", i, seq[i], vram_rd, seq[i] % 8 < 6); end
            if (seq[i] == 8) begin
                n_cmp++;
                if (outs !== cell_bytes(vv, 0)) begin n_err++; $display("FAIL jump_refetch got %h want %h", outs, cell_bytes(vv, 0)); end
            end
            if (seq[i] == 24) begin
                n_cmp++;
                if (outs !== cell_bytes(vv, 16)) begin n_err++; $display("FAIL jump_recover got %h want %h", outs, cell_bytes(vv, 16)); end
            end
            next_cycle();
        end
    endtask

    // Full frame, 200 clocks per line with h wrapping to 0, random VRAM and CPU traffic.
    task automatic test_frame();
        int hq[$];
        int vq[$];
        int eh, ev;
        logic exp_rd;
        for (int i = 0; i < 6 * 8192; i++) mem[i] = 8'($urandom);
        reset_n = 1'b0; h = 9'd0; v = 9'd0; cpu_req = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        for (int vv = 0; vv < 186; vv++) begin
            for (int hh = 0; hh < 200; hh++) begin
                h = 9'(hh); v = 9'(vv);
                cpu_req = 1'($urandom_range(0, 1));
                hq.push_back(hh); vq.push_back(vv);
                exp_rd = (hh < 192) && (vv < 184) && (hh % 8 < 6);
                @(negedge clk);
                n_cmp++;
                if ({vram_rd, cpu_grant} !== {exp_rd, cpu_req && !exp_rd}) begin
                    n_err++; $display("FAIL frame_arb v=%0d h=%0d got rd=%b grant=%b want %b/%b", vv, hh, vram_rd, cpu_grant, exp_rd, cpu_req && !exp_rd);
                end
                if (exp_rd) begin
                    n_cmp++;
                    if ({vram_bank, vram_addr} !== {3'(hh % 8), cell_addr(vv, hh)}) begin
                        n_err++; $display("FAIL frame_addr v=%0d h=%0d got bank=%0d addr=%h want %0d/%h", vv, hh, vram_bank, vram_addr, hh % 8, cell_addr(vv, hh));
                    end
                end
                if (hq.size() > 8) begin
                    eh = hq.pop_front();
                    ev = vq.pop_front();
                    n_cmp++;
                    if ({h_out, v_out} !== {9'(eh), 9'(ev)}) begin n_err++; $display("FAIL frame_hv got %0d/%0d want %0d/%0d", h_out, v_out, eh, ev); end
                    n_cmp++;
                    if (outs !== cell_bytes(ev, eh)) begin n_err++; $display("FAIL frame_pix v_out=%0d h_out=%0d got %h want %h", ev, eh, outs, cell_bytes(ev, eh)); end
                end
                next_cycle();
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; h = 9'd0; v = 9'd0; cpu_req = 1'b0;
        for (int i = 0; i < 6 * 8192; i++) mem[i] = 8'($urandom);
        #1;
        test_reset();
        test_first_cell();
        test_last_cell();
        test_inactive();
        for (int r = 0; r < 4; r++) test_cpu_priority();
        for (int r = 0; r < 3; r++) test_mid_reset();
        test_h_jump();
        test_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gfx_fetch.md
GFX_FETCH -- requirements
Module: gfx_fetch

Interface
REQ-001 Parameter: LINE_BASE, default 13'h0EC0, VRAM offset of line 0 / cell 0 in every plane bank.
REQ-002 Parameter: H_ACTIVE, default 192, active pixels per line; V_ACTIVE, default 184, active lines.
REQ-003 clk  in  1  pixel clock; all state changes on rising edge.
REQ-004 reset_n  in  1  synchronous reset, active-low.
REQ-005 h, v  in  9 each  raster counters from timing generator; h advances by 1 per clk.
REQ-006 vram_bank  out  3  plane select for current read: 0..5 = fg1,fg2,fg3,bg1,bg2,bg3.
REQ-007 vram_addr  out  13  byte address within selected bank.
REQ-008 vram_rd  out  1  read strobe; data returned on vram_data exactly 1 clk later.
REQ-009 vram_data  in  8  read data.
REQ-010 cpu_req  in  1  CPU requests VRAM access this cycle.
REQ-011 cpu_grant  out  1  CPU owns VRAM port this cycle (combinational from cpu_req, h, v).
REQ-012 fg1, fg2, fg3, bg1, bg2, bg3  out  8 each  plane bytes for the cell currently shown on h_out.
REQ-013 h_out, v_out  out  9 each  h, v delayed exactly 8 clks; drive the pixel stage's h, v.

Function
REQ-014 Active cell: h < H_ACTIVE and v < V_ACTIVE, evaluated on the h, v of slot 0 of the cell (h[2:0]==0); flag held for the cell.
REQ-015 Slot = h[2:0]; in an active cell, slots 0..5 SHALL issue vram_rd with vram_bank = slot, vram_addr = LINE_BASE + v*24 + h[8:3], 13-bit result, no wrap check (max 13'h1FFF at v=183, cell 23).
REQ-016 Address arithmetic: v*24 computed as (v<<4)+(v<<3), ≥13-bit intermediate, truncated to 13 bits after adding LINE_BASE.
REQ-017 Read data for slot k SHALL be captured into staging register k on the clk when slot == k+1 (slots 1..6).
REQ-018 On the clk where slot == 7, staging registers SHALL transfer to fg1..bg3; outputs hold for the following 8 clks.
REQ-019 Inactive cell: no vram_rd; at slot 7 all six outputs load 8'h00.
REQ-020 Alignment: bytes fetched for cell n of line v appear on outputs while h_out[8:3] == n and v_out == v.
REQ-021 Arbitration: fetch has absolute priority in slots 0..5 of an active cell; cpu_grant = cpu_req otherwise (slots 6,7 of active cells, all inactive cells).
REQ-022 vram_rd and cpu_grant SHALL never be 1 in the same clk.
REQ-023 h jump (non-consecutive h, e.g. wrap to 0) mid-cell: slot follows new h[2:0]; partially fetched staging data may be transferred; no hang, no extra reads outside REQ-015 slots.
REQ-024 h_out/v_out: 8-stage shift registers, no other transformation.

Reset
REQ-025 While reset_n == 0 at clk: fg1..bg3 = 0, staging = 0, h_out = v_out = 0, delay stages = 0, active flag = 0.
REQ-026 During reset vram_rd = 0; cpu_grant = cpu_req.
REQ-027 First clk after reset_n rises: normal operation from current h, v; first transfer at the next slot 7.
REQ-028 Reset asserted mid-cell aborts the fetch; no staging data survives.

Verification
REQ-029 v=0, h=0..7, VRAM bank k byte at 13'h0EC0 = 8'h11*(k+1) -> reads banks 0..5 at addr 13'h0EC0, slots 0..5; at h=8 outputs fg1=11,fg2=22,fg3=33,bg1=44,bg2=55,bg3=66, h_out=0.
REQ-030 v=183, h=184..191 -> vram_addr = 13'h1FFF each read; data appears with h_out=184, v_out=183.
REQ-031 h=192..199 on any line, cpu_req=1 -> vram_rd=0 all 8 clks, cpu_grant=1 all 8 clks, outputs 0 from h=200.
REQ-032 Active cell, cpu_req=1 throughout -> cpu_grant=0 in slots 0..5, 1 in slots 6,7; fetch data intact.
REQ-033 reset_n=0 at slot 3 of active cell for 1 clk -> next clk all outputs 0, vram_rd=0; fetch resumes at next slot 0.
REQ-034 Full-frame run with random VRAM -> pixel stage output matches golden model bit-exact; no cycle with vram_rd and cpu_grant both 1.
